// File: rtl/systolic_sequencer_pkg.sv
// Shared types and default sizes for the PairHMM systolic sequencer.
package systolic_sequencer_pkg;

   // Sequencer FSM states.
   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StCompute,
      StAdvance,
      StFinish
   } seq_state_t;

   localparam int unsigned NumPeDefault = 4;
   localparam int unsigned ColWDefault  = 8;
   localparam int unsigned StepWDefault = 9;

endpackage

// File: rtl/systolic_sequencer_if.sv
// Command/status and PE-array control bundle of the systolic sequencer.
interface systolic_sequencer_if
   import systolic_sequencer_pkg::*;
#(
   parameter int unsigned NUM_PE = NumPeDefault,
   parameter int unsigned COL_W  = ColWDefault,
   parameter int unsigned STEP_W = StepWDefault
) ();

   logic                    start;
   logic [COL_W-1:0]        read_len;
   logic [COL_W-1:0]        hap_len;
   logic [NUM_PE-1:0]       pe_done;
   logic                    array_clr;
   logic                    advance;
   logic [NUM_PE-1:0]       pe_enable;
   logic [NUM_PE*COL_W-1:0] col_idx;
   logic [STEP_W-1:0]       step;
   logic                    busy;
   logic                    done;
   logic                    err;

   // Sequencer side.
   modport master (
      input  start, read_len, hap_len, pe_done,
      output array_clr, advance, pe_enable, col_idx, step, busy, done, err
   );

   // Host / PE-array side.
   modport slave (
      output start, read_len, hap_len, pe_done,
      input  array_clr, advance, pe_enable, col_idx, step, busy, done, err
   );

endinterface

// File: rtl/systolic_sequencer_wavefront_decode.sv
// Anti-diagonal decode: which PEs are active at step t and their column indices.
module systolic_sequencer_wavefront_decode #(
   parameter int unsigned NUM_PE = 4,
   parameter int unsigned COL_W  = 8,
   parameter int unsigned STEP_W = 9
) (
   input  logic [STEP_W-1:0]       step_i,
   input  logic [COL_W-1:0]        read_len_i,
   input  logic [COL_W-1:0]        hap_len_i,
   output logic [NUM_PE-1:0]       pe_enable_o,
   output logic [NUM_PE*COL_W-1:0] col_idx_o
);

   localparam int unsigned DiffW = STEP_W + 1;

   logic [DiffW-1:0] rlen_ext;
   logic [DiffW-1:0] hlen_ext;

   assign rlen_ext = DiffW'(read_len_i);
   assign hlen_ext = DiffW'(hap_len_i);

   for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
      logic signed [DiffW-1:0] diff;
      logic                    in_range;

      // Range check on the full signed width; truncate only once it passes.
      assign diff     = $signed({1'b0, step_i}) - $signed(DiffW'(i));
      assign in_range = (DiffW'(i) < rlen_ext) && !diff[DiffW-1] &&
                        (diff < $signed(hlen_ext));

      assign pe_enable_o[i]               = in_range;
      assign col_idx_o[i*COL_W +: COL_W]  = in_range ? diff[COL_W-1:0] : '0;
   end

endmodule

// File: rtl/systolic_sequencer.sv
// Wavefront sequencer for the PairHMM PE array: steps anti-diagonals, waits for
// all active PEs, pulses advance, and flags completion, bad commands and stalls.
module systolic_sequencer
   import systolic_sequencer_pkg::*;
#(
   parameter int unsigned NUM_PE  = NumPeDefault,
   parameter int unsigned COL_W   = ColWDefault,
   parameter int unsigned STEP_W  = StepWDefault,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic                  clk,
   input logic                  reset,
   systolic_sequencer_if.master bus_io
);

   localparam int unsigned SumW = STEP_W + 1;
   localparam int unsigned WdW  = $clog2(TIMEOUT);
   // Abort when the watchdog is about to reach TIMEOUT-1 so that err/array_clr
   // land in the TIMEOUT-th cycle counted from COMPUTE entry.
   localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT - 2);

   seq_state_t        state_q;
   logic [STEP_W-1:0] step_q;
   logic [COL_W-1:0]  rlen_q;
   logic [COL_W-1:0]  hlen_q;
   logic [WdW-1:0]    wd_q;
   logic              array_clr_q;
   logic              advance_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic [NUM_PE-1:0]       dec_enable;
   logic [NUM_PE*COL_W-1:0] dec_col;
   logic                    bad_cmd;
   logic                    all_done;
   logic                    last_step;

   systolic_sequencer_wavefront_decode #(
      .NUM_PE (NUM_PE),
      .COL_W  (COL_W),
      .STEP_W (STEP_W)
   ) u_decode (
      .step_i      (step_q),
      .read_len_i  (rlen_q),
      .hap_len_i   (hlen_q),
      .pe_enable_o (dec_enable),
      .col_idx_o   (dec_col)
   );

   assign bad_cmd   = (bus_io.read_len == '0) || (bus_io.hap_len == '0) ||
                      (32'(bus_io.read_len) > NUM_PE);
   // Bits of PEs outside the current wavefront are masked off.
   assign all_done  = ((bus_io.pe_done & dec_enable) == dec_enable);
   assign last_step = (SumW'(step_q) + SumW'(2)) == (SumW'(rlen_q) + SumW'(hlen_q));

   // Control FSM, step counter, watchdog and registered pulse outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         step_q      <= '0;
         rlen_q      <= '0;
         hlen_q      <= '0;
         wd_q        <= '0;
         array_clr_q <= 1'b0;
         advance_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         array_clr_q <= 1'b0;
         advance_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus_io.start) begin
                  if (bad_cmd) begin
                     err_q <= 1'b1;
                  end else begin
                     rlen_q      <= bus_io.read_len;
                     hlen_q      <= bus_io.hap_len;
                     step_q      <= '0;
                     array_clr_q <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= StClear;
                  end
               end
            end
            StClear: begin
               wd_q    <= '0;
               state_q <= StCompute;
            end
            StCompute: begin
               if (all_done) begin
                  advance_q <= 1'b1;
                  state_q   <= StAdvance;
               end else if (wd_q == WdLimit) begin
                  err_q       <= 1'b1;
                  array_clr_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            StAdvance: begin
               if (last_step) begin
                  done_q  <= 1'b1;
                  state_q <= StFinish;
               end else begin
                  step_q  <= step_q + 1'b1;
                  wd_q    <= '0;
                  state_q <= StCompute;
               end
            end
            StFinish: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.pe_enable = (state_q == StCompute) ? dec_enable : '0;
   assign bus_io.col_idx   = (state_q == StCompute) ? dec_col : '0;
   assign bus_io.step      = step_q;
   assign bus_io.array_clr = array_clr_q;
   assign bus_io.advance   = advance_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.done      = done_q;
   assign bus_io.err       = err_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a small PE done-latency model.
module tb_systolic_sequencer;

   localparam int unsigned NUM_PE = 4;
   localparam int unsigned COL_W  = 8;
   localparam int unsigned STEP_W = 9;

   logic clk;
   logic reset;

   int n_vec;
   int n_miss;

   logic [31:0] rec_en  [16];
   logic [31:0] rec_col [16];
   bit          rec_seen[16];

   systolic_sequencer_if #(.NUM_PE(NUM_PE), .COL_W(COL_W), .STEP_W(STEP_W)) bus ();

   systolic_sequencer #(
      .NUM_PE  (NUM_PE),
      .COL_W   (COL_W),
      .STEP_W  (STEP_W),
      .TIMEOUT (16)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"},   32'(bus.busy), 0);
      check_eq({tag, "_en"},     32'(bus.pe_enable), 0);
      check_eq({tag, "_col"},    32'(bus.col_idx), 0);
      check_eq({tag, "_step"},   32'(bus.step), 0);
      check_eq({tag, "_pulses"}, 32'({bus.advance, bus.done, bus.err, bus.array_clr}), 0);
   endtask

   // Issue one command at cycle 0 and observe until two cycles past done/err.
   // PE i reports done after base_dly (+pe1_dly for PE1) enabled cycles.
   task automatic run_cmd(input int r, input int h, input int base_dly, input int pe1_dly,
                          input int spur_cyc, input int restart_cyc,
                          output int n_adv, output int n_clr, output int n_busy,
                          output int n_done, output int done_cyc, output int err_cyc,
                          output int last_clr);
      int cnt[NUM_PE];
      int stop_at;
      int n_adv_en;
      logic [NUM_PE-1:0] pd;
      n_adv = 0; n_clr = 0; n_busy = 0; n_done = 0;
      done_cyc = -1; err_cyc = -1; last_clr = -1; stop_at = -1; n_adv_en = 0;
      for (int i = 0; i < NUM_PE; i++) cnt[i] = 0;
      for (int s = 0; s < 16; s++) begin
         rec_seen[s] = 1'b0; rec_en[s] = '0; rec_col[s] = '0;
      end
      @(posedge clk); #1;
      bus.read_len = COL_W'(r);
      bus.hap_len  = COL_W'(h);
      bus.pe_done  = '0;
      bus.start    = 1'b1;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(posedge clk); #1;
         bus.start = (cyc == restart_cyc);
         if (bus.advance) begin
            n_adv++;
            if (bus.pe_enable != '0) n_adv_en++;
            for (int i = 0; i < NUM_PE; i++) cnt[i] = 0;
         end
         if (bus.array_clr) begin n_clr++; last_clr = cyc; end
         if (bus.busy) n_busy++;
         if (bus.done) begin n_done++; done_cyc = cyc; end
         if (bus.err) err_cyc = cyc;
         if (bus.pe_enable != '0 && bus.step < 16 && !rec_seen[bus.step[3:0]]) begin
            rec_seen[bus.step[3:0]] = 1'b1;
            rec_en[bus.step[3:0]]   = 32'(bus.pe_enable);
            rec_col[bus.step[3:0]]  = 32'(bus.col_idx);
         end
         if (spur_cyc > 0 && cyc == spur_cyc + 1) check_eq("spur_no_adv", 32'(bus.advance), 0);
         pd = '0;
         for (int i = 0; i < NUM_PE; i++) begin
            if (bus.pe_enable[i]) begin
               if (cnt[i] >= base_dly + ((i == 1) ? pe1_dly : 0)) pd[i] = 1'b1;
               cnt[i]++;
            end
         end
         if (cyc == spur_cyc) pd[3] = 1'b1;
         bus.pe_done = pd;
         if (stop_at < 0 && (bus.done || bus.err)) stop_at = cyc + 2;
         if (cyc == stop_at) break;
      end
      bus.pe_done = '0;
      check_eq("run_ends", 32'(stop_at >= 0), 1);
      check_eq("adv_en_zero", 32'(n_adv_en), 0);
   endtask

   int n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr;
   logic [31:0] exp_en [5];
   logic [31:0] exp_col[5];

   initial begin
      n_vec = 0; n_miss = 0;
      reset = 1'b1;
      bus.start = 1'b0; bus.read_len = '0; bus.hap_len = '0; bus.pe_done = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;

      // R=2, H=3, done 3 cycles after enable: 4 steps of 5 cycles.
      run_cmd(2, 3, 3, 0, -1, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      exp_en  = '{32'h1, 32'h3, 32'h3, 32'h2, 32'h0};
      exp_col = '{32'h0, 32'h0001, 32'h0102, 32'h0200, 32'h0};
      for (int s = 0; s < 4; s++) begin
         check_eq($sformatf("r2h3_en_t%0d", s), rec_en[s], exp_en[s]);
         check_eq($sformatf("r2h3_col_t%0d", s), rec_col[s], exp_col[s]);
      end
      check_eq("r2h3_adv", 32'(n_adv), 4);
      check_eq("r2h3_done_n", 32'(n_done), 1);
      check_eq("r2h3_done_cyc", 32'(done_cyc), 22);
      check_eq("r2h3_busy_cyc", 32'(n_busy), 22);
      check_eq("r2h3_clr", 32'(n_clr), 1);

      // R=4, H=1, immediate done: enable walks one-hot, done at cycle 10.
      run_cmd(4, 1, 0, 0, -1, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      for (int s = 0; s < 4; s++) begin
         check_eq($sformatf("r4h1_en_t%0d", s), rec_en[s], 32'(1) << s);
         check_eq($sformatf("r4h1_col_t%0d", s), rec_col[s], 0);
      end
      check_eq("r4h1_adv", 32'(n_adv), 4);
      check_eq("r4h1_done_cyc", 32'(done_cyc), 10);

      // Straggler: PE1 seven cycles late, spurious pe_done[3] at cycle 6.
      run_cmd(3, 3, 0, 7, 6, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      exp_en  = '{32'h1, 32'h3, 32'h7, 32'h6, 32'h4};
      exp_col = '{32'h0, 32'h0001, 32'h000102, 32'h010200, 32'h020000};
      for (int s = 0; s < 5; s++) begin
         check_eq($sformatf("strag_en_t%0d", s), rec_en[s], exp_en[s]);
         check_eq($sformatf("strag_col_t%0d", s), rec_col[s], exp_col[s]);
      end
      check_eq("strag_adv", 32'(n_adv), 5);
      check_eq("strag_done_cyc", 32'(done_cyc), 33);

      // Bad commands: R=0 and R>NUM_PE.
      run_cmd(0, 5, 0, 0, -1, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      check_eq("bad_r0_err", 32'(err_cyc), 1);
      check_eq("bad_r0_quiet", 32'(n_clr + n_adv + n_busy + n_done), 0);
      run_cmd(5, 2, 0, 0, -1, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      check_eq("bad_r5_err", 32'(err_cyc), 1);
      check_eq("bad_r5_quiet", 32'(n_clr + n_adv + n_busy + n_done), 0);

      // Timeout: never done; err and array_clr together 16 cycles into COMPUTE.
      run_cmd(1, 1, 100, 0, -1, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      check_eq("to_err_cyc", 32'(err_cyc), 17);
      check_eq("to_clr_cyc", 32'(last_clr), 17);
      check_eq("to_clr_n", 32'(n_clr), 2);
      check_eq("to_busy_cyc", 32'(n_busy), 16);
      check_eq("to_adv", 32'(n_adv), 0);
      run_cmd(4, 1, 0, 0, -1, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      check_eq("post_to_done_cyc", 32'(done_cyc), 10);
      check_eq("post_to_err", 32'(err_cyc), 32'hffff_ffff);

      // Start while busy is ignored.
      run_cmd(2, 3, 3, 0, -1, 8, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      check_eq("rs_adv", 32'(n_adv), 4);
      check_eq("rs_clr", 32'(n_clr), 1);
      check_eq("rs_done_cyc", 32'(done_cyc), 22);
      check_eq("rs_col_t2", rec_col[2], 32'h0102);

      // Single-step command R=1, H=1.
      run_cmd(1, 1, 0, 0, -1, -1, n_adv, n_clr, n_busy, n_done, done_cyc, err_cyc, last_clr);
      check_eq("r1h1_adv", 32'(n_adv), 1);
      check_eq("r1h1_done_cyc", 32'(done_cyc), 4);

      // Reset at step 2 aborts immediately.
      @(posedge clk); #1;
      bus.read_len = 8'd3; bus.hap_len = 8'd3; bus.pe_done = '1; bus.start = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.step == 2 && bus.pe_enable != '0) break;
      end
      check_eq("rst_reach_step2", 32'(bus.step), 2);
      reset = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("rst_mid");
      reset = 1'b0;
      bus.pe_done = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
